// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word-wide synchronous RAM
//
// Purpose:
//   Converts core load/store requests (byte address, size, signedness) into
//   word-indexed accesses on RAM port A with per-byte write enables. It aligns
//   and extends the returned load data. Accesses that cross a 32-bit word
//   boundary are issued as two back-to-back word accesses.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_valid/ready     request handshake; ready only while idle
//   req_address         byte address
//   req_write           1 = store, 0 = load
//   req_size            0 = byte, 1 = half, 2 = word, 3 = reserved (faults)
//   req_signed          sign-extend loads
//   req_write_data      right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_read_data      aligned/extended load data, 0 for stores and faults
//   resp_fault          access was rejected and not performed
//   ram_address         word index to RAM port A
//   ram_write_enable    byte-lane write enables
//   ram_write_data      lane-shifted store data
//   ram_read_data       RAM port A read data, one cycle after the address

module load_store_unit #(
    parameter int RAM_WORDS = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    output logic [31:0] resp_read_data,
    output logic        resp_fault,
    output logic [31:0] ram_address,
    output logic [3:0]  ram_write_enable,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

    state_t state;

    // Request decode, only meaningful in IDLE
    logic [1:0]  off;
    logic [29:0] w0;
    logic [29:0] w1;
    logic [2:0]  nbytes;
    logic [3:0]  nmask;
    logic        split;
    logic        req_fault;
    logic [7:0]  lane_mask8;
    logic [63:0] store_shift64;

    // Latched request for the WAIT states
    logic [1:0]  l_off;
    logic [1:0]  l_size;
    logic        l_write;
    logic        l_signed;
    logic        l_split;
    logic [29:0] l_w1;
    logic [3:0]  l_hi_mask;
    logic [31:0] l_hi_data;
    logic [31:0] lo_word;

    // Load assembly
    logic [63:0] assembled;
    logic [31:0] raw;
    logic [31:0] load_result;

    assign off = req_address[1:0];
    assign w0  = req_address[31:2];
    assign w1  = w0 + 30'd1;

    always_comb begin
        nbytes = 3'd4;
        nmask  = 4'b1111;
        case (req_size)
            2'd0: begin nbytes = 3'd1; nmask = 4'b0001; end
            2'd1: begin nbytes = 3'd2; nmask = 4'b0011; end
            default: begin nbytes = 3'd4; nmask = 4'b1111; end
        endcase
    end

    assign split = ({1'b0, off} + nbytes) > 3'd4;

    // Both word indices are checked up front so a bad second word also
    // suppresses the first-word write.
    assign req_fault = (req_size == 2'd3)
                    || ({2'b00, w0} >= RAM_LIMIT)
                    || (split && ({2'b00, w1} >= RAM_LIMIT));

    // Lanes [3:0] belong to word 0 and lanes [7:4] spill into word 1; the
    // same split applies to the 64-bit shifted store data.
    assign lane_mask8    = {4'b0000, nmask} << off;
    assign store_shift64 = {32'd0, req_write_data} << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            l_off     <= 2'd0;
            l_size    <= 2'd0;
            l_write   <= 1'b0;
            l_signed  <= 1'b0;
            l_split   <= 1'b0;
            l_w1      <= 30'd0;
            l_hi_mask <= 4'd0;
            l_hi_data <= 32'd0;
            lo_word   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_fault) begin
                            state <= FAULT;
                        end else begin
                            l_off     <= off;
                            l_size    <= req_size;
                            l_write   <= req_write;
                            l_signed  <= req_signed;
                            l_split   <= split;
                            l_w1      <= w1;
                            l_hi_mask <= lane_mask8[7:4];
                            l_hi_data <= store_shift64[63:32];
                            state     <= WAIT1;
                        end
                    end
                end
                WAIT1: begin
                    lo_word <= ram_read_data;
                    state   <= l_split ? WAIT2 : IDLE;
                end
                WAIT2:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // In WAIT2 the low bytes come from the word captured in WAIT1 and the
    // high bytes from the live read data; otherwise the live word alone.
    assign assembled = (state == WAIT2) ? {ram_read_data, lo_word}
                                        : {32'd0, ram_read_data};
    assign raw = assembled[{l_off, 3'b000} +: 32];

    always_comb begin
        load_result = raw;
        case (l_size)
            2'd0:    load_result = {{24{l_signed & raw[7]}},  raw[7:0]};
            2'd1:    load_result = {{16{l_signed & raw[15]}}, raw[15:0]};
            default: load_result = raw;
        endcase
    end

    always_comb begin
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_fault       = 1'b0;
        resp_read_data   = 32'd0;
        ram_address      = 32'd0;
        ram_write_enable = 4'd0;
        ram_write_data   = 32'd0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid && !req_fault) begin
                        ram_address = {2'b00, w0};
                        if (req_write) begin
                            ram_write_enable = lane_mask8[3:0];
                            ram_write_data   = store_shift64[31:0];
                        end
                    end
                end
                WAIT1: begin
                    if (l_split) begin
                        ram_address = {2'b00, l_w1};
                        if (l_write) begin
                            ram_write_enable = l_hi_mask;
                            ram_write_data   = l_hi_data;
                        end
                    end else begin
                        resp_valid     = 1'b1;
                        resp_read_data = l_write ? 32'd0 : load_result;
                    end
                end
                WAIT2: begin
                    resp_valid     = 1'b1;
                    resp_read_data = l_write ? 32'd0 : load_result;
                end
                default: begin
                    resp_valid = 1'b1;
                    resp_fault = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_write_data;
    logic        resp_valid;
    logic [31:0] resp_read_data;
    logic        resp_fault;
    logic [31:0] ram_address;
    logic [3:0]  ram_write_enable;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;

    int total;
    int bad;
    int cyc;
    int resp_count;

    logic [31:0] mem [0:8191];

    load_store_unit #(.RAM_WORDS(8192)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_address     (req_address),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_write_data  (req_write_data),
        .resp_valid      (resp_valid),
        .resp_read_data  (resp_read_data),
        .resp_fault      (resp_fault),
        .ram_address     (ram_address),
        .ram_write_enable(ram_write_enable),
        .ram_write_data  (ram_write_data),
        .ram_read_data   (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with byte enables, read-before-write
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (ram_write_enable[k])
                mem[ram_address[12:0]][8*k +: 8] <= ram_write_data[8*k +: 8];
        ram_read_data <= mem[ram_address[12:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (resp_valid) resp_count <= resp_count + 1;

    task automatic set_req(input logic v, input logic [31:0] a, input logic w,
                           input logic [1:0] sz, input logic sg, input logic [31:0] d);
        req_valid      = v;
        req_address    = a;
        req_write      = w;
        req_size       = sz;
        req_signed     = sg;
        req_write_data = d;
    endtask

    // Issues one request from IDLE and waits (bounded) for its response.
    task automatic run_access(input logic [31:0] a, input logic w, input logic [1:0] sz,
                              input logic sg, input logic [31:0] d,
                              output logic [31:0] rdata, output logic fault,
                              output int lat, output logic [3:0] we_acc);
        @(negedge clk);
        set_req(1'b1, a, w, sz, sg, d);
        #1;
        we_acc = ram_write_enable;
        lat    = -1;
        rdata  = 32'hXXXXXXXX;
        fault  = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
            #1;
            we_acc = we_acc | ram_write_enable;
            if (resp_valid) begin
                lat   = i;
                rdata = resp_read_data;
                fault = resp_fault;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(1'b1, 32'h100, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF);
        repeat (3) @(negedge clk);
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        total++; if (resp_fault !== 1'b0) begin bad++; $display("FAIL reset_resp_fault got %b want 0", resp_fault); end
        total++; if (resp_read_data !== 32'd0) begin bad++; $display("FAIL reset_rdata got %h want 0", resp_read_data); end
        total++; if (ram_write_enable !== 4'd0) begin bad++; $display("FAIL reset_we got %b want 0000", ram_write_enable); end
        total++; if (ram_address !== 32'd0) begin bad++; $display("FAIL reset_addr got %h want 0", ram_address); end
        set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_aligned_word();
        logic [31:0] rd; logic f; int lat; logic [3:0] we;
        @(negedge clk);
        set_req(1'b1, 32'h100, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
        #1;
        total++; if (ram_address !== 32'h40) begin bad++; $display("FAIL st_word_addr got %h want 00000040", ram_address); end
        total++; if (ram_write_enable !== 4'b1111) begin bad++; $display("FAIL st_word_we got %b want 1111", ram_write_enable); end
        total++; if (ram_write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL st_word_wd got %h want deadbeef", ram_write_data); end
        @(negedge clk);
        set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
        #1;
        total++; if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_read_data !== 32'd0) begin
            bad++; $display("FAIL st_word_resp got v=%b f=%b d=%h want v=1 f=0 d=0", resp_valid, resp_fault, resp_read_data); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wait1_ready got %b want 0", req_ready); end
        run_access(32'h100, 1'b0, 2'd2, 1'b0, 32'd0, rd, f, lat, we);
        total++; if (lat !== 1) begin bad++; $display("FAIL ld_word_latency got %0d want 1", lat); end
        total++; if (rd !== 32'hDEADBEEF || f !== 1'b0) begin bad++; $display("FAIL ld_word_data got %h f=%b want deadbeef f=0", rd, f); end
        total++; if (we !== 4'd0) begin bad++; $display("FAIL ld_word_we got %b want 0000", we); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic f; int lat; logic [3:0] we;
        run_access(32'h101, 1'b0, 2'd0, 1'b1, 32'd0, rd, f, lat, we);
        total++; if (rd !== 32'hFFFFFFBE) begin bad++; $display("FAIL ld_byte_signed got %h want ffffffbe", rd); end
        run_access(32'h101, 1'b0, 2'd0, 1'b0, 32'd0, rd, f, lat, we);
        total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL ld_byte_unsigned got %h want 000000be", rd); end
        run_access(32'h102, 1'b0, 2'd1, 1'b1, 32'd0, rd, f, lat, we);
        total++; if (rd !== 32'hFFFFDEAD) begin bad++; $display("FAIL ld_half_signed got %h want ffffdead", rd); end
        @(negedge clk);
        set_req(1'b1, 32'h103, 1'b1, 2'd0, 1'b0, 32'hFFFFFF55);
        #1;
        total++; if (ram_write_enable !== 4'b1000) begin bad++; $display("FAIL st_byte_we got %b want 1000", ram_write_enable); end
        total++; if (ram_write_data[31:24] !== 8'h55) begin bad++; $display("FAIL st_byte_lane3 got %h want 55", ram_write_data[31:24]); end
        @(negedge clk);
        set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
        run_access(32'h100, 1'b0, 2'd2, 1'b0, 32'd0, rd, f, lat, we);
        total++; if (rd !== 32'h55ADBEEF) begin bad++; $display("FAIL st_byte_readback got %h want 55adbeef", rd); end
    endtask

    task automatic test_split();
        logic [31:0] rd; logic f; int lat; logic [3:0] we;
        @(negedge clk);
        set_req(1'b1, 32'h1FE, 1'b1, 2'd2, 1'b0, 32'h11223344);
        #1;
        total++; if (ram_address !== 32'h7F || ram_write_enable !== 4'b1100) begin
            bad++; $display("FAIL split_c0 got a=%h we=%b want a=7f we=1100", ram_address, ram_write_enable); end
        total++; if (ram_write_data[31:16] !== 16'h3344) begin bad++; $display("FAIL split_c0_wd got %h want 3344", ram_write_data[31:16]); end
        @(negedge clk);
        set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
        #1;
        total++; if (ram_address !== 32'h80 || ram_write_enable !== 4'b0011) begin
            bad++; $display("FAIL split_c1 got a=%h we=%b want a=80 we=0011", ram_address, ram_write_enable); end
        total++; if (ram_write_data[15:0] !== 16'h1122) begin bad++; $display("FAIL split_c1_wd got %h want 1122", ram_write_data[15:0]); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL split_early_resp got %b want 0", resp_valid); end
        @(negedge clk);
        #1;
        total++; if (resp_valid !== 1'b1 || resp_read_data !== 32'd0) begin
            bad++; $display("FAIL split_st_resp got v=%b d=%h want v=1 d=0", resp_valid, resp_read_data); end
        run_access(32'h1FE, 1'b0, 2'd2, 1'b0, 32'd0, rd, f, lat, we);
        total++; if (lat !== 2) begin bad++; $display("FAIL split_ld_latency got %0d want 2", lat); end
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL split_ld_data got %h want 11223344", rd); end
        run_access(32'h1FF, 1'b0, 2'd1, 1'b1, 32'd0, rd, f, lat, we);
        total++; if (rd !== 32'h00002233 || lat !== 2) begin bad++; $display("FAIL split_half got %h lat=%0d want 00002233 lat=2", rd, lat); end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3] = '{32'h0, 32'h8000, 32'h7FFE};
        logic [1:0]  sizes [3] = '{2'd3, 2'd2, 2'd2};
        logic [31:0] rd; logic f; int lat; logic [3:0] we;
        for (int i = 0; i < 3; i++) begin
            run_access(addrs[i], 1'b1, sizes[i], 1'b0, 32'hCAFEF00D, rd, f, lat, we);
            total++; if (lat !== 1 || f !== 1'b1 || rd !== 32'd0 || we !== 4'd0) begin
                bad++; $display("FAIL fault_%0d got lat=%0d f=%b d=%h we=%b want lat=1 f=1 d=0 we=0000", i, lat, f, rd, we); end
        end
        run_access(32'h7FFC, 1'b0, 2'd2, 1'b0, 32'd0, rd, f, lat, we);
        total++; if (f !== 1'b0 || lat !== 1) begin bad++; $display("FAIL last_word_ok got f=%b lat=%0d want f=0 lat=1", f, lat); end
    endtask

    task automatic test_reset_mid_split();
        logic [31:0] rd; logic f; int lat; logic [3:0] we;
        int base;
        @(negedge clk);
        base = resp_count;
        set_req(1'b1, 32'h2FE, 1'b1, 2'd2, 1'b0, 32'hAABBCCDD);
        @(negedge clk);
        set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
        reset = 1'b1;
        #1;
        total++; if (ram_write_enable !== 4'd0 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_split_wait1 got we=%b v=%b want we=0000 v=0", ram_write_enable, resp_valid); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_split_after got ready=%b v=%b want ready=1 v=0", req_ready, resp_valid); end
        @(negedge clk);
        #1;
        total++; if (resp_count !== base) begin bad++; $display("FAIL rst_split_no_resp got %0d want %0d", resp_count, base); end
        run_access(32'h300, 1'b0, 2'd2, 1'b0, 32'd0, rd, f, lat, we);
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL rst_split_w1 got %h want 00000000", rd); end
        run_access(32'h2FE, 1'b0, 2'd1, 1'b0, 32'd0, rd, f, lat, we);
        total++; if (rd !== 32'h0000CCDD) begin bad++; $display("FAIL rst_split_w0 got %h want 0000ccdd", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h100, 32'h1FC, 32'h200};
        logic [31:0] exp   [3] = '{32'h55ADBEEF, 32'h33440000, 32'h00001122};
        int acc [3];
        int base;
        int guard;
        @(negedge clk);
        base = resp_count;
        set_req(1'b1, addrs[0], 1'b0, 2'd2, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            guard = 0;
            while (!req_ready && guard < 10) begin
                @(negedge clk);
                #1;
                guard++;
            end
            total++; if (guard >= 10) begin bad++; $display("FAIL b2b_accept_timeout got %0d want <10", guard); end
            acc[k] = cyc;
            if (k > 0) begin
                total++; if (acc[k] - acc[k-1] !== 2) begin
                    bad++; $display("FAIL b2b_spacing_%0d got %0d want 2", k, acc[k] - acc[k-1]); end
            end
            @(negedge clk);
            if (k < 2) set_req(1'b1, addrs[k+1], 1'b0, 2'd2, 1'b0, 32'd0);
            else       set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
            #1;
            total++; if (resp_valid !== 1'b1 || resp_read_data !== exp[k]) begin
                bad++; $display("FAIL b2b_resp_%0d got v=%b d=%h want v=1 d=%h", k, resp_valid, resp_read_data, exp[k]); end
        end
        @(negedge clk);
        #1;
        total++; if (resp_count - base !== 3) begin bad++; $display("FAIL b2b_count got %0d want 3", resp_count - base); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        resp_count = 0;
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        reset = 1'b1;
        set_req(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 32'd0);
        test_reset();
        test_aligned_word();
        test_byte_half();
        test_split();
        test_faults();
        test_reset_mid_split();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits directly upstream of the dual-port block RAM's port A. It converts core load/store requests (byte address, size, signedness) into word-indexed RAM accesses with per-byte write enables. It aligns and extends returned read data. Accesses that straddle a 32-bit word boundary are split into two consecutive RAM word accesses under a small state machine, so misaligned loads and stores complete without a trap.

Parameters:
RAM_WORDS, 8192, number of 32-bit words backed by RAM (4 banks x 2048); word indices >= RAM_WORDS fault

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid & req_ready
req_address  input  32  byte address
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
req_signed  input  1  load sign-extends when 1; ignored for stores
req_write_data  input  32  store data, right-aligned (bits [8*n-1:0] used)
resp_valid  output  1  one-cycle pulse: request completed
resp_read_data  output  32  aligned, extended load data; 0 for stores and faults
resp_fault  output  1  qualifies resp_valid: access not performed
ram_address  output  32  word index (byte address >> 2) to RAM port A
ram_write_enable  output  4  byte-lane enables; lane k = bits [8k+7:8k]
ram_write_data  output  32  lane-shifted store data
ram_read_data  input  32  RAM port A data, valid one cycle after address

Behaviour:
- States: IDLE, WAIT1, WAIT2, FAULT. RAM port outputs are combinational from the state and the request/latched request. Synchronous RAM has 1-cycle read latency.
- Reset state: IDLE. While reset=1: req_ready=0, resp_valid=0, resp_fault=0, resp_read_data=0, ram_write_enable=0, ram_address=0. No response is ever produced for a request in flight at reset.
- Definitions: n = 1, 2 or 4 bytes; off = req_address[1:0]; w0 = req_address[31:2]; split = off+n > 4; w1 = w0+1, wrapping modulo 2^30.
- IDLE: req_ready=1.
  - On accept with size 3, or w0 >= RAM_WORDS, or (split and w1 >= RAM_WORDS): no write enable asserted; go to FAULT.
  - Otherwise drive ram_address=w0. For stores, assert enables on lanes off..min(off+n,4)-1, with ram_write_data = req_write_data << 8*off. Latch request; go to WAIT1.
- WAIT1: req_ready=0. Capture the word-0 lanes from ram_read_data.
  - If split: drive ram_address=w1. For stores, assert enables on lanes 0..off+n-5 with the remaining high bytes of the data. Go to WAIT2.
  - Else: resp_valid=1; go to IDLE.
- WAIT2: resp_valid=1. For loads, the upper bytes come from ram_read_data. Go to IDLE.
- FAULT: resp_valid=1, resp_fault=1, resp_read_data=0; go to IDLE.
- Latency, accept to resp_valid: 1 cycle aligned or fault, 2 cycles split. Minimum issue interval is 2 cycles (3 if split). req_ready=1 only in IDLE.
- Load data assembly: little-endian, byte i of the result = memory byte at address+i. Bits above 8n are sign-extended from bit 8n-1 if req_signed, else zero. For stores, resp_read_data=0.
- There is no response backpressure; the consumer must take resp_valid when asserted.
- req_* inputs are sampled only at accept; later changes have no effect.
- Stores to w0 complete before the w1 write. A fault on w1 suppresses the w0 write as well, because it is checked at accept.

Test Plan:
- Aligned word: store 0xDEADBEEF at 0x100, then load word at 0x100 -> ram_address=0x40 and enable=4'b1111 on store; load resp_valid 1 cycle after accept, data 0xDEADBEEF, fault=0.
- Byte/half extension: after the above, load byte signed at 0x101 -> 0xFFFFFFBE; load byte unsigned at 0x101 -> 0x000000BE; load half signed at 0x102 -> 0xFFFFDEAD; store byte 0x55 at 0x103 -> enable=4'b1000, data lane3=0x55.
- Split: store word 0x11223344 at 0x1FE -> cycle 0 w0=0x7F enable=4'b1100; cycle 1 w1=0x80 enable=4'b0011; load word at 0x1FE -> resp 2 cycles after accept = 0x11223344.
- Faults: size=3 at 0x0; word at byte 0x8000 (w0=8192); word at 0x7FFE (w1=8192) -> resp_fault=1 after 1 cycle, data 0, no enable asserted in any cycle.
- Reset mid-split: reset=1 during WAIT1 of a split store -> second-word enable never asserted, no resp_valid; state IDLE and req_ready=1 on the first cycle after reset deasserts.
- Back-to-back: req_valid held high with 3 aligned loads -> accepts spaced exactly 2 cycles apart, 3 resp_valid pulses in order with correct data.
